// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants and the per-axis phase encoding,
// used by the sync generator and the renderers that consume its counters.
package vga_timing_pkg;

    localparam int VGA_HPIXELS = 800;
    localparam int VGA_VLINES  = 521;
    localparam int VGA_HPULSE  = 96;
    localparam int VGA_VPULSE  = 2;
    localparam int VGA_HBP     = 144;
    localparam int VGA_HFP     = 784;
    localparam int VGA_VBP     = 31;
    localparam int VGA_VFP     = 511;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        BACK   = 2'd1,
        ACTIVE = 2'd2,
        FRONT  = 2'd3
    } phase_e;

endpackage

// File: rtl/vga_axis_timer.sv
// One timing axis: wrap counter advanced by step_i, phase FSM, sync and window
// decode. The next-count view is exported so the top can register coherent flags.
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int N     = VGA_HPIXELS,
    parameter int PULSE = VGA_HPULSE,
    parameter int BP    = VGA_HBP,
    parameter int FP    = VGA_HFP
) (
    input  logic       clk25,
    input  logic       clr,
    input  logic       step_i,
    output logic [9:0] cnt_o,
    output logic       tc_o,
    output logic       tc_nxt_o,
    output logic       active_nxt_o,
    output logic       sync_n_o
);

    logic [9:0] cnt_q, cnt_d;
    phase_e     phase_q, phase_d;
    logic       sync_n_q;

    // Phase follows the count that will be presented next, so sync and
    // window flags line up with the counter in the same cycle.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (step_i) begin
            cnt_d = (cnt_q == 10'(N - 1)) ? 10'd0 : cnt_q + 10'd1;
            if (cnt_d == 10'd0)
                phase_d = SYNC;
            else if (cnt_d == 10'(PULSE))
                phase_d = BACK;
            else if (cnt_d == 10'(BP))
                phase_d = ACTIVE;
            else if (cnt_d == 10'(FP))
                phase_d = FRONT;
        end
    end

    always_ff @(posedge clk25 or posedge clr) begin
        if (clr) begin
            cnt_q    <= 10'd0;
            phase_q  <= SYNC;
            sync_n_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            sync_n_q <= (phase_d != SYNC);
        end
    end

    assign cnt_o        = cnt_q;
    assign tc_o         = (cnt_q == 10'(N - 1));
    assign tc_nxt_o     = (cnt_d == 10'(N - 1));
    assign active_nxt_o = (phase_d == ACTIVE);
    assign sync_n_o     = sync_n_q;

endmodule

// File: rtl/vga_sync_640x480.sv
// 640x480@60 Hz sync generator: horizontal axis steps every enabled clock,
// vertical axis steps on horizontal wrap; window and strobes are registered.
module vga_sync_640x480
    import vga_timing_pkg::*;
#(
    parameter int HPIXELS = VGA_HPIXELS,
    parameter int VLINES  = VGA_VLINES,
    parameter int HPULSE  = VGA_HPULSE,
    parameter int VPULSE  = VGA_VPULSE,
    parameter int HBP     = VGA_HBP,
    parameter int HFP     = VGA_HFP,
    parameter int VBP     = VGA_VBP,
    parameter int VFP     = VGA_VFP
) (
    input  logic       clk25,
    input  logic       clr,
    input  logic       en,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hsync,
    output logic       vsync,
    output logic       vidon,
    output logic       line_end,
    output logic       frame_end
);

    logic h_tc, h_tc_nxt, h_act_nxt;
    logic v_tc, v_tc_nxt, v_act_nxt;
    logic vidon_q, line_end_q, frame_end_q;

    vga_axis_timer #(.N(HPIXELS), .PULSE(HPULSE), .BP(HBP), .FP(HFP)) u_h (
        .clk25        (clk25),
        .clr          (clr),
        .step_i       (en),
        .cnt_o        (hc),
        .tc_o         (h_tc),
        .tc_nxt_o     (h_tc_nxt),
        .active_nxt_o (h_act_nxt),
        .sync_n_o     (hsync)
    );

    vga_axis_timer #(.N(VLINES), .PULSE(VPULSE), .BP(VBP), .FP(VFP)) u_v (
        .clk25        (clk25),
        .clr          (clr),
        .step_i       (en & h_tc),
        .cnt_o        (vc),
        .tc_o         (v_tc),
        .tc_nxt_o     (v_tc_nxt),
        .active_nxt_o (v_act_nxt),
        .sync_n_o     (vsync)
    );

    // Strobes are gated by en so a frozen terminal count never re-fires.
    always_ff @(posedge clk25 or posedge clr) begin
        if (clr) begin
            vidon_q     <= 1'b0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            vidon_q     <= h_act_nxt & v_act_nxt;
            line_end_q  <= en & h_tc_nxt;
            frame_end_q <= en & h_tc_nxt & v_tc_nxt;
        end
    end

    assign vidon     = vidon_q;
    assign line_end  = line_end_q;
    assign frame_end = frame_end_q;

    logic unused_v_tc;
    assign unused_v_tc = v_tc;

endmodule

// File: tb/tb_vga_sync_640x480.sv
// Bench for vga_sync_640x480: full-size horizontal timing with a shortened
// frame, checked every cycle against a counter-arithmetic model.
module tb_vga_sync_640x480;

    localparam int HP = 800, HPU = 96, HB = 144, HF = 784;
    localparam int VL = 24,  VPU = 2,  VB = 5,   VF = 21;

    logic       clk25 = 1'b0, clr = 1'b1, en = 1'b1;
    logic [9:0] hc, vc;
    logic       hsync, vsync, vidon, line_end, frame_end;

    int n_chk = 0, n_fail = 0;

    vga_sync_640x480 #(
        .HPIXELS(HP), .VLINES(VL), .HPULSE(HPU), .VPULSE(VPU),
        .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF)
    ) dut (
        .clk25(clk25), .clr(clr), .en(en), .hc(hc), .vc(vc),
        .hsync(hsync), .vsync(vsync), .vidon(vidon),
        .line_end(line_end), .frame_end(frame_end)
    );

    always #20 clk25 = ~clk25;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: position in the raster plus whether the last edge was enabled.
    int mh = 0, mv = 0;
    bit mstrobe = 0;
    always @(posedge clk25 or posedge clr) begin
        if (clr) begin
            mh = 0; mv = 0; mstrobe = 0;
        end else if (en) begin
            mstrobe = 1;
            if (mh == HP - 1) begin
                mh = 0;
                mv = (mv + 1) % VL;
            end else
                mh = mh + 1;
        end else
            mstrobe = 0;
    end

    function automatic logic [24:0] expected();
        logic hs, vs, vid, le, fe;
        hs  = !(mh < HPU);
        vs  = !(mv < VPU);
        vid = (mh >= HB) && (mh < HF) && (mv >= VB) && (mv < VF);
        le  = mstrobe && (mh == HP - 1);
        fe  = le && (mv == VL - 1);
        return {10'(mh), 10'(mv), hs, vs, vid, le, fe};
    endfunction

    bit prev_vs = 0;
    always @(negedge clk25) begin
        check("cycle {hc,vc,hs,vs,vid,le,fe}",
              int'({hc, vc, hsync, vsync, vidon, line_end, frame_end}),
              int'(expected()));
        if (vsync && !prev_vs) begin
            check("vsync rise hc", int'(hc), 0);
            check("vsync rise vc", int'(vc), 2);
        end
        prev_vs = vsync;
    end

    task automatic wait_pos(input int v, input int h, input string name);
        int k = 0;
        while (!(int'(vc) == v && int'(hc) == h) && k < 3 * VL * HP) begin
            @(negedge clk25); k++;
        end
        if (k >= 3 * VL * HP) check({name, " timeout"}, 1, 0);
    endtask

    initial begin
        int cnt_hs, cnt_vid, cnt_le, n, v0;
        // reset
        repeat (3) begin
            @(negedge clk25);
            check("reset all outputs",
                  int'({hc, vc, hsync, vsync, vidon, line_end, frame_end}), 0);
        end
        clr = 1'b0;
        @(negedge clk25);
        check("first hc", int'(hc), 1);
        check("first vc", int'(vc), 0);
        check("first hsync", int'(hsync), 0);

        // one visible line
        wait_pos(VB + 3, 0, "visible line");
        cnt_hs = 0; cnt_vid = 0; cnt_le = 0;
        repeat (HP) begin
            if (!hsync) cnt_hs++;
            if (vidon) cnt_vid++;
            if (line_end) begin
                cnt_le++;
                check("line_end hc", int'(hc), 799);
            end
            @(negedge clk25);
        end
        check("hsync low width", cnt_hs, 96);
        check("vidon width", cnt_vid, 640);
        check("line_end count", cnt_le, 1);

        // enable hold mid-line
        wait_pos(10, 300, "hold point");
        en = 1'b0;
        repeat (10) begin
            @(negedge clk25);
            check("hold hc", int'(hc), 300);
            check("hold vc", int'(vc), 10);
            check("hold strobes", int'({line_end, frame_end}), 0);
        end
        en = 1'b1;
        @(negedge clk25);
        check("resume hc", int'(hc), 301);

        // enable low at line wrap
        wait_pos(11, 799, "wrap point");
        v0 = int'(vc);
        en = 1'b0;
        repeat (5) begin
            @(negedge clk25);
            check("wrap hold line_end", int'(line_end), 0);
            check("wrap hold vc", int'(vc), v0);
        end
        en = 1'b1;
        @(negedge clk25);
        check("after wrap hc", int'(hc), 0);
        check("after wrap vc", int'(vc), v0 + 1);

        // random enable
        repeat (20000) begin
            en = ($urandom_range(0, 7) != 0);
            @(negedge clk25);
        end
        en = 1'b1;

        // frame wrap
        n = 0;
        while (!frame_end && n < 3 * VL * HP) begin @(negedge clk25); n++; end
        check("frame_end seen", int'(frame_end), 1);
        check("frame_end vc", int'(vc), VL - 1);
        check("frame_end hc", int'(hc), 799);
        @(negedge clk25);
        check("post-frame pos", int'({vc, hc}), 0);
        cnt_le = 0;
        repeat (VL * HP - 1) begin
            @(negedge clk25);
            if (frame_end) cnt_le++;
        end
        check("frame_end pulses per frame", cnt_le, 1);

        // async mid-frame reset
        wait_pos(12, 500, "reset point");
        #5 clr = 1'b1;
        #1 check("async clr outputs",
                 int'({hc, vc, hsync, vsync, vidon, line_end, frame_end}), 0);
        @(negedge clk25);
        clr = 1'b0;
        n = 0;
        do begin @(negedge clk25); n++; end
        while (!frame_end && n < 2 * VL * HP);
        check("period after reset", n + 1, VL * HP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
